// File: rtl/pulse_sched_pkg.sv
// Shared types and helpers for the pulse window scheduler.
// Channel search works on an 8-bit mask, which covers every legal N_CH.
package pulse_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int MAX_CH = 8;

  // Returns {found, index} of the lowest set bit at or above position 'from'.
  function automatic logic [3:0] next_set_bit(input logic [7:0] mask, input logic [3:0] from);
    logic [3:0] r;
    r = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= from)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/pulse_window_sched_bin2gray.sv
// Combinational binary to Gray-code converter.
module bin2gray #(
  parameter int W = 8
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/pulse_window_sched.sv
// Shares one pulse-accumulation window across N_CH channels, sweeping enabled
// channels in ascending order and handing each Gray-coded count out via valid/ready.
//
// state | meaning
// IDLE  | waiting for start with a nonzero mask
// ARM   | clear accumulator, load window counter
// COUNT | accumulate pulses of the selected channel
// HOLD  | result presented, waiting for res_ready
module pulse_window_sched
  import pulse_sched_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int WIN_W = 8,
  parameter  int CNT_W = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             cont,
  input  logic [N_CH-1:0]  ch_mask,
  input  logic [WIN_W-1:0] window_len,
  input  logic [N_CH-1:0]  pulse,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_data,
  output logic [SEL_W-1:0] res_ch,
  output logic             res_ovf,
  output logic             sweep_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [N_CH-1:0]  mask_q;
  logic [WIN_W-1:0] wlen_q, win_cnt;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] acc_q, acc_d, gray_d;
  logic             ovf_q, ovf_d;
  logic             latch, capture, xfer, last_xfer;
  logic [3:0]       first_bit, next_bit;

  assign first_bit = next_set_bit(8'(ch_mask), 4'd0);
  assign next_bit  = next_set_bit(8'(mask_q), 4'(sel_q) + 4'd1);

  // Saturating accumulate; overflow only when a pulse arrives at full scale.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (pulse[sel_q]) begin
      if (acc_q == CNT_MAX) ovf_d = 1'b1;
      else                  acc_d = acc_q + CNT_W'(1);
    end
  end

  bin2gray #(.W(CNT_W)) u_gray (
    .bin  (acc_d),
    .gray (gray_d)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    latch     = 1'b0;
    capture   = 1'b0;
    xfer      = 1'b0;
    last_xfer = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && first_bit[3]) begin
          latch   = 1'b1;
          sel_d   = first_bit[SEL_W-1:0];
          state_d = ARM;
        end
      end
      ARM: state_d = COUNT;
      COUNT: begin
        if (win_cnt == WIN_W'(1)) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (res_valid && res_ready) begin
          xfer = 1'b1;
          if (next_bit[3]) begin
            sel_d   = next_bit[SEL_W-1:0];
            state_d = ARM;
          end else begin
            last_xfer = 1'b1;
            state_d   = IDLE;
            if (cont) begin
              latch = 1'b1;
              if (first_bit[3]) begin
                sel_d   = first_bit[SEL_W-1:0];
                state_d = ARM;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Everything, outputs included, freezes while enable is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      sel_q      <= '0;
      mask_q     <= '0;
      wlen_q     <= '0;
      win_cnt    <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_ch     <= '0;
      res_ovf    <= 1'b0;
    end else if (enable) begin
      state_q    <= state_d;
      busy       <= (state_d != IDLE);
      sweep_done <= last_xfer;
      sel_q      <= sel_d;
      if (latch) begin
        mask_q <= ch_mask;
        wlen_q <= window_len;
      end
      case (state_q)
        ARM: begin
          acc_q   <= '0;
          ovf_q   <= 1'b0;
          win_cnt <= (wlen_q == '0) ? WIN_W'(1) : wlen_q;
        end
        COUNT: begin
          acc_q   <= acc_d;
          ovf_q   <= ovf_d;
          win_cnt <= win_cnt - WIN_W'(1);
        end
        default: ;
      endcase
      if (capture) begin
        res_valid <= 1'b1;
        res_data  <= gray_d;
        res_ch    <= sel_q;
        res_ovf   <= ovf_d;
      end else if (xfer) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_window_sched.sv
// Directed bench for pulse_window_sched: an 8-bit and a 4-bit count instance
// share the same stimulus; expected values are hand-computed per step.
module tb_pulse_window_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       start;
  logic       cont;
  logic [3:0] ch_mask;
  logic [7:0] window_len;
  logic [3:0] pulse;
  logic       res_ready;

  logic       busy, res_valid, res_ovf, sweep_done;
  logic [7:0] res_data;
  logic [1:0] res_ch;
  logic       busy4, res_valid4, res_ovf4, sweep_done4;
  logic [3:0] res_data4;
  logic [1:0] res_ch4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pulse_window_sched #(.N_CH(4), .WIN_W(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .cont(cont),
    .ch_mask(ch_mask), .window_len(window_len), .pulse(pulse), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_ch(res_ch), .res_ovf(res_ovf), .sweep_done(sweep_done)
  );

  pulse_window_sched #(.N_CH(4), .WIN_W(8), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .cont(cont),
    .ch_mask(ch_mask), .window_len(window_len), .pulse(pulse), .busy(busy4),
    .res_valid(res_valid4), .res_ready(res_ready), .res_data(res_data4),
    .res_ch(res_ch4), .res_ovf(res_ovf4), .sweep_done(sweep_done4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; start = 1'b0; cont = 1'b0;
    ch_mask = '0; window_len = '0; pulse = '0; res_ready = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(res_valid), 0);
    check("rst_data", 32'(res_data), 0);
    check("rst_ch", 32'(res_ch), 0);
    check("rst_ovf", 32'(res_ovf), 0);
    check("rst_done", 32'(sweep_done), 0);
    step(); reset = 1'b0;
    step();

    // zero mask start is ignored
    start = 1'b1; ch_mask = 4'b0000;
    step(); start = 1'b0;
    check("zero_mask_busy", 32'(busy), 0);

    // two-channel sweep: ch0 every cycle, ch2 three pulses
    ch_mask = 4'b0101; window_len = 8'd5; res_ready = 1'b1; pulse = 4'b0001; start = 1'b1;
    step(); start = 1'b0;
    check("sw_busy", 32'(busy), 1);
    step(6);
    check("sw0_valid", 32'(res_valid), 1);
    check("sw0_ch", 32'(res_ch), 0);
    check("sw0_data", 32'(res_data), 32'h07);
    step();
    check("sw0_xfer", 32'(res_valid), 0);
    step(); pulse = 4'b0101;
    step(3); pulse = 4'b0001;
    step(2);
    check("sw2_valid", 32'(res_valid), 1);
    check("sw2_ch", 32'(res_ch), 2);
    check("sw2_data", 32'(res_data), 32'h02);
    step();
    check("sw_done", 32'(sweep_done), 1);
    check("sw_busy_low", 32'(busy), 0);
    check("sw_valid_low", 32'(res_valid), 0);
    step();
    check("sw_done_pulse", 32'(sweep_done), 0);

    // window_len 0 behaves as a single-cycle window
    ch_mask = 4'b0001; window_len = 8'd0; pulse = 4'b0000; start = 1'b1;
    step(); start = 1'b0; pulse = 4'b0001;
    step(2); pulse = 4'b0000;
    check("w0_valid", 32'(res_valid), 1);
    check("w0_data", 32'(res_data), 32'h01);
    step();
    check("w0_done", 32'(sweep_done), 1);

    // full window: 255 pulses fit in 8 bits, saturate the 4-bit instance
    ch_mask = 4'b0001; window_len = 8'd255; pulse = 4'b0001; start = 1'b1;
    step(); start = 1'b0;
    step(255);
    check("full_not_yet", 32'(res_valid), 0);
    step();
    check("full_valid", 32'(res_valid), 1);
    check("full_data8", 32'(res_data), 32'h80);
    check("full_ovf8", 32'(res_ovf), 0);
    check("full_data4", 32'(res_data4), 32'h8);
    check("full_ovf4", 32'(res_ovf4), 1);
    step(2);

    // backpressure in HOLD for 10 cycles
    ch_mask = 4'b0011; window_len = 8'd2; pulse = 4'b0011; res_ready = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    step(3);
    check("bp_valid", 32'(res_valid), 1);
    check("bp_ch", 32'(res_ch), 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold_valid", 32'(res_valid), 1);
      check("bp_hold_data", 32'(res_data), 32'h03);
      check("bp_hold_ch", 32'(res_ch), 0);
    end
    res_ready = 1'b1;
    step();
    check("bp_xfer", 32'(res_valid), 0);
    step(2);
    check("bp_ch1_not_yet", 32'(res_valid), 0);
    step();
    check("bp_ch1_valid", 32'(res_valid), 1);
    check("bp_ch1_ch", 32'(res_ch), 1);
    check("bp_ch1_data", 32'(res_data), 32'h03);
    step();
    check("bp_done", 32'(sweep_done), 1);
    check("bp_busy_low", 32'(busy), 0);

    // continuous mode, mask cleared during sweep
    cont = 1'b1; ch_mask = 4'b0001; window_len = 8'd1; pulse = 4'b0001; start = 1'b1;
    step(); start = 1'b0; ch_mask = 4'b0000;
    step(2);
    check("c0_valid", 32'(res_valid), 1);
    check("c0_data", 32'(res_data), 32'h01);
    step();
    check("c0_done", 32'(sweep_done), 1);
    check("c0_idle", 32'(busy), 0);
    step();
    check("c0_stay_idle", 32'(busy), 0);

    // continuous mode, new mask selects ch3 for the second sweep
    ch_mask = 4'b0001; start = 1'b1;
    step(); start = 1'b0; ch_mask = 4'b1000; pulse = 4'b1001;
    step(3);
    check("c1_done", 32'(sweep_done), 1);
    check("c1_busy", 32'(busy), 1);
    cont = 1'b0;
    step(2);
    check("c1_valid", 32'(res_valid), 1);
    check("c1_ch", 32'(res_ch), 3);
    check("c1_data", 32'(res_data), 32'h01);
    step();
    check("c1_idle", 32'(busy), 0);

    // enable low for 3 cycles mid-window
    ch_mask = 4'b0001; window_len = 8'd4; pulse = 4'b0001; res_ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    step(3); enable = 1'b0;
    step(3);
    check("fz_busy", 32'(busy), 1);
    check("fz_valid", 32'(res_valid), 0);
    enable = 1'b1;
    step();
    check("fz_extended", 32'(res_valid), 0);
    step();
    check("fz_valid_after", 32'(res_valid), 1);
    check("fz_data", 32'(res_data), 32'h06);
    step();

    // asynchronous reset mid-COUNT
    ch_mask = 4'b0001; window_len = 8'd10; start = 1'b1;
    step(); start = 1'b0;
    step(3);
    #2 reset = 1'b1;
    #1;
    check("ar_busy", 32'(busy), 0);
    check("ar_valid", 32'(res_valid), 0);
    check("ar_data", 32'(res_data), 0);
    check("ar_ch", 32'(res_ch), 0);
    check("ar_ovf", 32'(res_ovf), 0);
    check("ar_done", 32'(sweep_done), 0);
    step(); reset = 1'b0;
    step(12);
    check("ar_stay_idle", 32'(busy), 0);
    check("ar_no_result", 32'(res_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
